// File: rtl/gated_clk_burst_rx_pkg.sv
// Shared definitions for the gated-clock burst receiver: FSM encoding, defaults, edge latency.
// Optional GLITCH_FILTER_EN selects the filtered edge latency constant.
// Pure declarations, no logic.
package gcb_rx_pkg;

  // FSM state encoding; the enum documents the states, the localparams drive the RTL
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } gcb_state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_IDLE_CYCLES = 16;
  localparam int DEF_TMR_W       = 16;

  // cycles from first high sample of burst_in to the edge pulse
  localparam int EDGE_LAT_NOFILT = 3;
  localparam int EDGE_LAT_FILT   = 5;
`ifdef GLITCH_FILTER_EN
  localparam int EDGE_LAT = EDGE_LAT_FILT;
`else
  localparam int EDGE_LAT = EDGE_LAT_NOFILT;
`endif

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/gated_clk_burst_rx_sync_edge_det.sv
// Synchronizes the async burst pin and emits a one-cycle pulse per rising edge.
// Latency 3 clk (5 clk with GLITCH_FILTER_EN majority filter).
// No backpressure; free-running every cycle.
module sync_edge_det
  import gcb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic edge_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_edge;

`ifdef GLITCH_FILTER_EN
  logic r_s3;
  logic r_s4;
  logic r_lvl;
  logic r_lvl_d;
  logic w_maj;

  // majority of the last three synchronized samples rejects 1-cycle glitches
  assign w_maj = maj3(r_s2, r_s3, r_s4);

  // synchronizer, sample history, filtered level and registered rising-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_s4    <= 1'b0;
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_s1    <= din;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_s4    <= r_s3;
      r_lvl   <= w_maj;
      r_lvl_d <= r_lvl;
      r_edge  <= r_lvl & ~r_lvl_d;
    end
  end
`else
  logic r_s3;

  // two-flop synchronizer followed by a registered rising-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_s1   <= din;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_edge <= r_s2 & ~r_s3;
    end
  end
`endif

  assign edge_pulse = r_edge;

endmodule

// File: rtl/gated_clk_burst_rx.sv
// Counts rising edges per burst on a gated-clock pin; a burst ends after IDLE_CYCLES quiet cycles.
// Result appears IDLE_CYCLES cycles after the last edge pulse (edge pulse is 3 clk, or 5 with GLITCH_FILTER_EN, after the pin).
// Result held on out_valid/out_count until out_ready; edges arriving while held set overrun and are dropped.
module gated_clk_burst_rx
  import gcb_rx_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int TMR_W       = DEF_TMR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             burst_in,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic             overrun,
  output logic             saturated
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TMR_W-1:0] TMR_END = TMR_W'(IDLE_CYCLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [TMR_W-1:0] r_timer;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_out_count;
  logic             r_overrun;
  logic             r_saturated;

  logic w_edge;
  logic w_ovr_set;
  logic w_sat_set;

  sync_edge_det u_sync_edge_det (
    .clk        (clk),
    .rst        (rst),
    .din        (burst_in),
    .edge_pulse (w_edge)
  );

  // an edge while a result waits (and is not taken this cycle) is an overrun
  assign w_ovr_set = (r_state == ST_HOLD) & w_edge & ~out_ready;
  // an edge arriving when the count is already full saturates
  assign w_sat_set = (r_state == ST_COUNT) & w_edge & (r_cnt == CNT_MAX);

  // burst FSM: counter, idle timer and the held result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            r_state <= ST_COUNT;
            r_cnt   <= CNT_W'(1);
            r_timer <= '0;
          end
        end
        ST_COUNT: begin
          if (w_edge) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
            r_timer <= '0;
          end else if (r_timer == TMR_END) begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_out_count <= r_cnt;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_HOLD: begin
          // edges without a handshake are discarded; a handshake edge starts the next burst
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_edge) begin
              r_state <= ST_COUNT;
              r_cnt   <= CNT_W'(1);
              r_timer <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // sticky status flags; a set condition beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun   <= 1'b0;
      r_saturated <= 1'b0;
    end else begin
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (clr_ovr) r_overrun <= 1'b0;
      if (w_sat_set)    r_saturated <= 1'b1;
      else if (clr_ovr) r_saturated <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign overrun   = r_overrun;
  assign saturated = r_saturated;

endmodule

// File: tb/tb_gated_clk_burst_rx.sv
// Randomized and directed bench for gated_clk_burst_rx against a behavioural burst model.
// Edge timing is derived from the pin history; bursts are tracked as pending/active results.
// Out_ready is driven fixed-high, fixed-low or random per phase.
module tb_gated_clk_burst_rx;

  localparam int CW   = 4;
  localparam int IC   = 16;
  localparam int CMAX = (1 << CW) - 1;
`ifdef GLITCH_FILTER_EN
  localparam int HI = 3;
`else
  localparam int HI = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          burst_in;
  logic          out_ready;
  logic          clr_ovr;
  logic          out_valid;
  logic [CW-1:0] out_count;
  logic          overrun;
  logic          saturated;

  always #5 clk = ~clk;

  gated_clk_burst_rx #(.CNT_W(CW), .IDLE_CYCLES(IC), .TMR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .burst_in  (burst_in),
    .out_ready (out_ready),
    .clr_ovr   (clr_ovr),
    .out_valid (out_valid),
    .out_count (out_count),
    .overrun   (overrun),
    .saturated (saturated)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural model: pin history, pending result, burst in progress
  bit mv, mo, ms, mact;
  int mc, mcur, mquiet;
  bit hq[$];

  int  rdy_mode;
  bit  clr_req;
  bit  cap_en;
  int  got_q[$];
  int  exp_q[$];

  // pin sample taken d cycles ago (flops were cleared at reset, so older history reads 0)
  function automatic bit at(input int d);
    return (d <= hq.size()) ? hq[d-1] : 1'b0;
  endfunction

  function automatic bit filt(input int d);
    int s;
    s = int'(at(d)) + int'(at(d+1)) + int'(at(d+2));
    return s >= 2;
  endfunction

  // a rising edge is recognised a fixed latency after the pin is first seen high
  function automatic bit edge_now();
`ifdef GLITCH_FILTER_EN
    return filt(4) && !filt(5);
`else
    return at(3) && !at(4);
`endif
  endfunction

  task automatic model_step();
    bit e, hs, so, ss;
    if (rst) begin
      mv = 0; mc = 0; mo = 0; ms = 0; mact = 0; mcur = 0; mquiet = 0;
      hq.delete();
      return;
    end
    e  = edge_now();
    hs = mv && out_ready;
    so = mv && e && !out_ready;
    ss = !mv && mact && e && (mcur == CMAX);
    if (mv) begin
      if (hs) begin
        mv = 0;
        mact = e;
        mcur = e ? 1 : 0;
        mquiet = 0;
      end
    end else if (mact) begin
      if (e) begin
        if (mcur < CMAX) mcur++;
        mquiet = 0;
      end else if (mquiet == IC - 1) begin
        mv = 1; mc = mcur; mact = 0;
      end else begin
        mquiet++;
      end
    end else if (e) begin
      mact = 1; mcur = 1; mquiet = 0;
    end
    if (so) mo = 1; else if (clr_ovr) mo = 0;
    if (ss) ms = 1; else if (clr_ovr) ms = 0;
    hq.push_front(burst_in);
    if (hq.size() > 8) void'(hq.pop_back());
  endtask

  task automatic tick(input bit b);
    burst_in = b;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    clr_ovr = clr_req;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(mv));
    chk("out_count", 32'(out_count), 32'(mc));
    chk("overrun",   32'(overrun),   32'(mo));
    chk("saturated", 32'(saturated), 32'(ms));
    if (cap_en && out_valid === 1'b1 && out_ready) got_q.push_back(int'(out_count));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      repeat (hi) tick(1'b1);
      repeat (lo) tick(1'b0);
    end
  endtask

  task automatic quiet(input int k);
    repeat (k) tick(1'b0);
  endtask

  task automatic clear_flags();
    clr_req = 1'b1;
    tick(1'b0);
    clr_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; burst_in = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
    rdy_mode = 1; clr_req = 1'b0; cap_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick(1'b0);            // still in reset: outputs must be at reset values
    rst = 1'b0;
    quiet(4);

    // 5-pulse burst, consumer always ready
    rdy_mode = 0;
    pulses(5, HI, HI); quiet(30); exp_q.push_back(5);

    // held result while consumer stalls 40 cycles
    rdy_mode = 1;
    pulses(3, HI, HI); quiet(60);
    rdy_mode = 0; quiet(3); exp_q.push_back(3);

    // overrun: edges while a result is pending are dropped
    rdy_mode = 1;
    pulses(2, HI, HI); quiet(25);
    pulses(2, HI, HI); quiet(8);
    rdy_mode = 0; quiet(3); exp_q.push_back(2);
    pulses(4, HI, HI); quiet(25); exp_q.push_back(4);
    clear_flags(); quiet(2);

    // saturation at 2^CW-1
    pulses(20, HI, HI); quiet(25); exp_q.push_back(CMAX);
    clear_flags(); quiet(2);

    // gap boundary: 15 quiet cycles keep one burst, 16 and 17 split it
    pulses(1, HI, 16 - HI); pulses(1, HI, 30); exp_q.push_back(2);
    pulses(1, HI, 17 - HI); pulses(1, HI, 30); exp_q.push_back(1); exp_q.push_back(1);
    pulses(1, HI, 18 - HI); pulses(1, HI, 30); exp_q.push_back(1); exp_q.push_back(1);

    // reset in the middle of a burst loses it
    pulses(3, HI, HI);
    rst = 1'b1; tick(1'b0); rst = 1'b0;
    quiet(30);

`ifdef GLITCH_FILTER_EN
    // single-cycle highs are filtered out, 3-cycle pulses count
    pulses(5, 1, 3); quiet(30);
    pulses(3, 3, 3); quiet(25); exp_q.push_back(3);
`endif

    chk("n_results", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("result", 32'(got_q[i]), 32'(exp_q[i]));

    // random bursts, gaps, stalls and flag clears against the model
    cap_en = 1'b0;
    rdy_mode = 2;
    for (int j = 0; j < 40; j++) begin
      pulses($urandom_range(1, 20), $urandom_range(HI, HI + 3), $urandom_range(HI, HI + 3));
      quiet($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) clear_flags();
    end
    quiet(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
